// File: rtl/regfile_pkg.sv
// Shared constants and write-port priority helpers for the parameterised register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 16;
    localparam int DEFAULT_NUM_REGS = 16;

    typedef enum logic [1:0] {
        WP_NONE = 2'd0,
        WP_1    = 2'd1,
        WP_2    = 2'd2,
        WP_SP   = 2'd3
    } wp_sel_e;

    // Special port beats port 2, which beats port 1.
    function automatic wp_sel_e wp_pick(input logic hit1, input logic hit2, input logic hit_sp);
        if (hit_sp) begin
            return WP_SP;
        end else if (hit2) begin
            return WP_2;
        end else if (hit1) begin
            return WP_1;
        end
        return WP_NONE;
    endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port write-forwarding select; only exists in builds with REGFILE_BYPASS_EN.
`ifdef REGFILE_BYPASS_EN
module regfile_bypass_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = 4,
    parameter int SP_REG  = 15,
    parameter int ZERO_R0 = 1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              wr_en2,
    input  logic [ADDR_W-1:0] wr_addr2,
    input  logic [DATA_W-1:0] wr_data2,
    input  logic              sp_wr_en,
    input  logic [DATA_W-1:0] sp_wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_REG);

    wp_sel_e sel;

    always_comb begin
        sel = wp_pick(wr_en1 && (wr_addr1 == rd_addr),
                      wr_en2 && (wr_addr2 == rd_addr),
                      sp_wr_en && (rd_addr == SP_ADDR));
        case (sel)
            WP_SP:   rd_data = sp_wr_data;
            WP_2:    rd_data = wr_data2;
            WP_1:    rd_data = wr_data1;
            default: rd_data = stored;
        endcase
        if ((ZERO_R0 != 0) && (rd_addr == '0)) begin
            rd_data = '0;
        end
    end

endmodule
`endif

// File: rtl/param_regfile.sv
// Multi-ported register file with a dedicated special register and same-address write arbitration.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module param_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int SP_REG   = NUM_REGS - 1,
    parameter int ZERO_R0  = 1
) (
    input  logic              CLOCK,
    input  logic              CLEAR,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] rd_data_sp,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              wr_en2,
    input  logic [ADDR_W-1:0] wr_addr2,
    input  logic [DATA_W-1:0] wr_data2,
    input  logic              sp_wr_en,
    input  logic [DATA_W-1:0] sp_wr_data,
    output logic              wr_conflict
);

    localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_REG);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              armed_q;
    logic              conflict_q;
    logic              conflict_d;
    logic              e1, e2, esp;

    // armed_q stays low through the first edge after CLEAR rises, so a write on that edge is dropped.
    always_ff @(posedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    // Writes aimed at a hard-wired zero R0 are dropped up front so they never arbitrate or conflict.
    assign e1  = armed_q && wr_en1 && !((ZERO_R0 != 0) && (wr_addr1 == '0));
    assign e2  = armed_q && wr_en2 && !((ZERO_R0 != 0) && (wr_addr2 == '0));
    assign esp = armed_q && sp_wr_en && !((ZERO_R0 != 0) && (SP_REG == 0));

    assign conflict_d = (e1 && e2 && (wr_addr1 == wr_addr2))
                      || (e1 && esp && (wr_addr1 == SP_ADDR))
                      || (e2 && esp && (wr_addr2 == SP_ADDR));

    always_ff @(posedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign wr_conflict = conflict_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            wp_sel_e           sel;
            logic [DATA_W-1:0] reg_d;

            assign sel = wp_pick(e1 && (wr_addr1 == ADDR_W'(gi)),
                                 e2 && (wr_addr2 == ADDR_W'(gi)),
                                 esp && (gi == SP_REG));

            always_comb begin
                reg_d = regs_q[gi];
                case (sel)
                    WP_SP:   reg_d = sp_wr_data;
                    WP_2:    reg_d = wr_data2;
                    WP_1:    reg_d = wr_data1;
                    default: reg_d = regs_q[gi];
                endcase
            end

            always_ff @(posedge CLOCK or negedge CLEAR) begin
                if (!CLEAR) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= reg_d;
                end
            end
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    logic [ADDR_W-1:0] bp_addr   [3];
    logic [DATA_W-1:0] bp_stored [3];
    logic [DATA_W-1:0] bp_out    [3];

    assign bp_addr[0] = rd_addr1;
    assign bp_addr[1] = rd_addr2;
    assign bp_addr[2] = SP_ADDR;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_bypass
            assign bp_stored[gi] = regs_q[bp_addr[gi]];

            regfile_bypass_mux #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .SP_REG  (SP_REG),
                .ZERO_R0 (ZERO_R0)
            ) u_bypass (
                .rd_addr    (bp_addr[gi]),
                .stored     (bp_stored[gi]),
                .wr_en1     (e1),
                .wr_addr1   (wr_addr1),
                .wr_data1   (wr_data1),
                .wr_en2     (e2),
                .wr_addr2   (wr_addr2),
                .wr_data2   (wr_data2),
                .sp_wr_en   (esp),
                .sp_wr_data (sp_wr_data),
                .rd_data    (bp_out[gi])
            );
        end
    endgenerate

    assign rd_data1   = bp_out[0];
    assign rd_data2   = bp_out[1];
    assign rd_data_sp = bp_out[2];
`else
    // R0 is never written when hard-wired, so its stored zero doubles as the read value.
    assign rd_data1   = regs_q[rd_addr1];
    assign rd_data2   = regs_q[rd_addr2];
    assign rd_data_sp = regs_q[SP_ADDR];
`endif

endmodule

// File: tb/tb_param_regfile.sv
// Self-checking bench for param_regfile: directed vector table, reset corner sequences,
// randomized traffic against a behavioural model, and a 32x32 instance.
module tb_param_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        CLOCK = 1'b0;
    logic        CLEAR = 1'b0;
    logic [3:0]  rd_addr1, rd_addr2, wr_addr1, wr_addr2;
    logic [15:0] rd_data1, rd_data2, rd_data_sp, wr_data1, wr_data2, sp_wr_data;
    logic        wr_en1, wr_en2, sp_wr_en, wr_conflict;

    logic [4:0]  b_rd_addr1, b_rd_addr2, b_wr_addr1, b_wr_addr2;
    logic [31:0] b_rd_data1, b_rd_data2, b_rd_data_sp, b_wr_data1, b_wr_data2, b_sp_wr_data;
    logic        b_wr_en1, b_wr_en2, b_sp_wr_en, b_wr_conflict;

    int tests = 0;
    int fails = 0;

    always #5 CLOCK = ~CLOCK;

    param_regfile dut (
        .CLOCK(CLOCK), .CLEAR(CLEAR),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data_sp(rd_data_sp),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
        .sp_wr_en(sp_wr_en), .sp_wr_data(sp_wr_data),
        .wr_conflict(wr_conflict)
    );

    param_regfile #(.DATA_W(32), .NUM_REGS(32)) dut_b (
        .CLOCK(CLOCK), .CLEAR(CLEAR),
        .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2),
        .rd_data1(b_rd_data1), .rd_data2(b_rd_data2), .rd_data_sp(b_rd_data_sp),
        .wr_en1(b_wr_en1), .wr_addr1(b_wr_addr1), .wr_data1(b_wr_data1),
        .wr_en2(b_wr_en2), .wr_addr2(b_wr_addr2), .wr_data2(b_wr_data2),
        .sp_wr_en(b_sp_wr_en), .sp_wr_data(b_sp_wr_data),
        .wr_conflict(b_wr_conflict)
    );

    typedef struct {
        logic        we1;
        logic [3:0]  a1;
        logic [15:0] d1;
        logic        we2;
        logic [3:0]  a2;
        logic [15:0] d2;
        logic        spe;
        logic [15:0] spd;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [15:0] exp1;
        logic [15:0] exp2;
        logic [15:0] exp_sp;
        logic        exp_c;
    } vec_t;

    vec_t        tbl [10];
    logic [15:0] mem [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: R0 reads zero; later ports in the order p1, p2, sp override earlier ones.
    function automatic logic [15:0] model_read(input logic [3:0] a, input vec_t v);
        logic [15:0] r;
        if (a == 4'd0) return 16'h0;
        r = mem[a];
        if (BYPASS) begin
            if (v.we1 && v.a1 == a) r = v.d1;
            if (v.we2 && v.a2 == a) r = v.d2;
            if (v.spe && a == 4'd15) r = v.spd;
        end
        return r;
    endfunction

    task automatic model_commit(input vec_t v);
        if (v.we1 && v.a1 != 4'd0) mem[v.a1] = v.d1;
        if (v.we2 && v.a2 != 4'd0) mem[v.a2] = v.d2;
        if (v.spe) mem[15] = v.spd;
    endtask

    function automatic bit model_conflict(input vec_t v);
        int cnt [16];
        for (int k = 0; k < 16; k++) cnt[k] = 0;
        if (v.we1 && v.a1 != 4'd0) cnt[v.a1]++;
        if (v.we2 && v.a2 != 4'd0) cnt[v.a2]++;
        if (v.spe) cnt[15]++;
        for (int k = 0; k < 16; k++) if (cnt[k] >= 2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input vec_t v);
        wr_en1 = v.we1; wr_addr1 = v.a1; wr_data1 = v.d1;
        wr_en2 = v.we2; wr_addr2 = v.a2; wr_data2 = v.d2;
        sp_wr_en = v.spe; sp_wr_data = v.spd;
        rd_addr1 = v.ra1; rd_addr2 = v.ra2;
    endtask

    task automatic idle();
        wr_en1 = 1'b0; wr_en2 = 1'b0; sp_wr_en = 1'b0;
    endtask

    task automatic mem_clear();
        for (int k = 0; k < 16; k++) mem[k] = 16'h0;
    endtask

    initial begin
        vec_t rv;
        vec_t w4;

        tbl[0] = '{1'b1, 4'd3,  16'h5A5A, 1'b0, 4'd0,  16'h0,    1'b0, 16'h0,    4'd3,  4'd3,  16'h5A5A, 16'h5A5A, 16'h0,    1'b0};
        tbl[1] = '{1'b1, 4'd15, 16'h1111, 1'b1, 4'd15, 16'h2222, 1'b1, 16'h3333, 4'd15, 4'd3,  16'h3333, 16'h5A5A, 16'h3333, 1'b1};
        tbl[2] = '{1'b0, 4'd0,  16'h0,    1'b0, 4'd0,  16'h0,    1'b0, 16'h0,    4'd15, 4'd15, 16'h3333, 16'h3333, 16'h3333, 1'b0};
        tbl[3] = '{1'b0, 4'd0,  16'h0,    1'b1, 4'd0,  16'hFFFF, 1'b0, 16'h0,    4'd0,  4'd3,  16'h0,    16'h5A5A, 16'h3333, 1'b0};
        tbl[4] = '{1'b1, 4'd0,  16'h1234, 1'b1, 4'd0,  16'h5678, 1'b0, 16'h0,    4'd0,  4'd0,  16'h0,    16'h0,    16'h3333, 1'b0};
        tbl[5] = '{1'b1, 4'd5,  16'h0055, 1'b1, 4'd5,  16'h00AA, 1'b0, 16'h0,    4'd5,  4'd5,  16'h00AA, 16'h00AA, 16'h3333, 1'b1};
        tbl[6] = '{1'b1, 4'd6,  16'h6666, 1'b1, 4'd7,  16'h7777, 1'b0, 16'h0,    4'd6,  4'd7,  16'h6666, 16'h7777, 16'h3333, 1'b0};
        tbl[7] = '{1'b0, 4'd0,  16'h0,    1'b1, 4'd15, 16'hBEEF, 1'b0, 16'h0,    4'd15, 4'd6,  16'hBEEF, 16'h6666, 16'hBEEF, 1'b0};
        tbl[8] = '{1'b1, 4'd15, 16'hCAFE, 1'b0, 4'd0,  16'h0,    1'b1, 16'h1357, 4'd15, 4'd5,  16'h1357, 16'h00AA, 16'h1357, 1'b1};
        tbl[9] = '{1'b1, 4'd4,  16'h0F0F, 1'b0, 4'd0,  16'h0,    1'b0, 16'h0,    4'd4,  4'd15, 16'h0F0F, 16'h1357, 16'h1357, 1'b0};

        mem_clear();
        idle();
        wr_addr1 = '0; wr_addr2 = '0; wr_data1 = '0; wr_data2 = '0; sp_wr_data = '0;
        rd_addr1 = 4'd1; rd_addr2 = 4'd2;
        b_wr_en1 = 1'b0; b_wr_en2 = 1'b0; b_sp_wr_en = 1'b0;
        b_wr_addr1 = '0; b_wr_addr2 = '0; b_wr_data1 = '0; b_wr_data2 = '0; b_sp_wr_data = '0;
        b_rd_addr1 = '0; b_rd_addr2 = '0;

        // Held in reset: everything reads zero.
        #3;
        chk("rst_low_rd1", rd_data1, 16'h0);
        chk("rst_low_rd2", rd_data2, 16'h0);
        chk("rst_low_sp", rd_data_sp, 16'h0);
        chk("rst_low_conflict", wr_conflict, 1'b0);

        // Release at t=10 with a write pending across the first edge: it must be dropped.
        #7;
        CLEAR = 1'b1;
        wr_en1 = 1'b1; wr_addr1 = 4'd4; wr_data1 = 16'h1234;
        @(posedge CLOCK); #1;
        idle();
        rd_addr1 = 4'd4;
        #1;
        chk("release_edge_write_dropped", rd_data1, 16'h0);
        rd_addr1 = 4'd1; rd_addr2 = 4'd2;
        #1;
        chk("post_reset_rd1", rd_data1, 16'h0);
        chk("post_reset_rd2", rd_data2, 16'h0);
        chk("post_reset_sp", rd_data_sp, 16'h0);
        chk("post_reset_conflict", wr_conflict, 1'b0);
        $display("[TB] reset sequence done");

        // Write-cycle visibility depends on forwarding; next cycle is always the new value.
        @(negedge CLOCK);
        wr_en1 = 1'b1; wr_addr1 = 4'd3; wr_data1 = 16'hA5A5; rd_addr1 = 4'd3;
        #1;
        chk("write_cycle_rd1", rd_data1, BYPASS ? 16'hA5A5 : 16'h0);
        @(posedge CLOCK); #1;
        idle();
        #1;
        chk("next_cycle_rd1", rd_data1, 16'hA5A5);
        mem[3] = 16'hA5A5;
        $display("[TB] write 3=0xa5a5 read back 0x%0h", rd_data1);

        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK);
            drive(tbl[i]);
            @(posedge CLOCK); #1;
            idle();
            rd_addr1 = tbl[i].ra1; rd_addr2 = tbl[i].ra2;
            #1;
            chk($sformatf("vec%0d_rd1", i), rd_data1, tbl[i].exp1);
            chk($sformatf("vec%0d_rd2", i), rd_data2, tbl[i].exp2);
            chk($sformatf("vec%0d_sp", i), rd_data_sp, tbl[i].exp_sp);
            chk($sformatf("vec%0d_conflict", i), wr_conflict, tbl[i].exp_c);
            model_commit(tbl[i]);
            $display("[TB] vec %0d rd1=0x%0h rd2=0x%0h sp=0x%0h conflict=%0b",
                     i, rd_data1, rd_data2, rd_data_sp, wr_conflict);
        end

        // Conflict pulse raised, then CLEAR drops mid-cycle: contents and flag clear immediately.
        @(negedge CLOCK);
        wr_en1 = 1'b1; wr_addr1 = 4'd9; wr_data1 = 16'h0001;
        wr_en2 = 1'b1; wr_addr2 = 4'd9; wr_data2 = 16'h0002;
        rd_addr1 = 4'd4;
        @(posedge CLOCK); #1;
        idle();
        #1;
        chk("pre_clear_conflict", wr_conflict, 1'b1);
        chk("pre_clear_rd4", rd_data1, 16'h0F0F);
        CLEAR = 1'b0;
        #1;
        chk("async_clear_rd4", rd_data1, 16'h0);
        chk("async_clear_conflict", wr_conflict, 1'b0);
        chk("async_clear_sp", rd_data_sp, 16'h0);
        mem_clear();

        w4 = '{1'b1, 4'd4, 16'h7777, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'd4, 4'd4, 16'h0, 16'h0, 16'h0, 1'b0};
        @(negedge CLOCK);
        drive(w4);
        @(posedge CLOCK); #1;
        chk("write_in_reset_ignored", rd_data1, 16'h0);
        @(negedge CLOCK);
        CLEAR = 1'b1;
        @(posedge CLOCK); #1;
        idle();
        #1;
        chk("release_edge_write_dropped2", rd_data1, 16'h0);
        @(negedge CLOCK);
        drive(w4);
        @(posedge CLOCK); #1;
        idle();
        #1;
        chk("first_armed_write", rd_data1, 16'h7777);
        model_commit(w4);
        $display("[TB] reset corner sequences done");

        for (int n = 0; n < 300; n++) begin
            rv.we1 = 1'($urandom_range(0, 1));
            rv.a1  = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            rv.d1  = 16'($urandom);
            rv.we2 = 1'($urandom_range(0, 1));
            rv.a2  = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            rv.d2  = 16'($urandom);
            rv.spe = ($urandom_range(0, 3) == 0);
            rv.spd = 16'($urandom);
            rv.ra1 = 4'($urandom_range(0, 15));
            rv.ra2 = ($urandom_range(0, 3) == 0) ? rv.ra1 : 4'($urandom_range(0, 15));
            rv.exp1 = '0; rv.exp2 = '0; rv.exp_sp = '0; rv.exp_c = 1'b0;
            @(negedge CLOCK);
            drive(rv);
            #1;
            chk($sformatf("rand%0d_rd1", n), rd_data1, model_read(rv.ra1, rv));
            chk($sformatf("rand%0d_rd2", n), rd_data2, model_read(rv.ra2, rv));
            chk($sformatf("rand%0d_sp", n), rd_data_sp, model_read(4'd15, rv));
            if (rv.ra1 == rv.ra2) chk($sformatf("rand%0d_same_addr", n), rd_data2, rd_data1);
            @(posedge CLOCK); #1;
            chk($sformatf("rand%0d_conflict", n), wr_conflict, model_conflict(rv));
            model_commit(rv);
        end
        idle();
        $display("[TB] random phase: 300 cycles");

        // 32x32 instance: special-port write visible on the dedicated and general read ports.
        @(negedge CLOCK);
        b_sp_wr_en = 1'b1; b_sp_wr_data = 32'hDEADBEEF; b_rd_addr2 = 5'd31;
        @(posedge CLOCK); #1;
        b_sp_wr_en = 1'b0;
        #1;
        chk("w32_sp", b_rd_data_sp, 32'hDEADBEEF);
        chk("w32_rd2", b_rd_data2, 32'hDEADBEEF);
        chk("w32_conflict", b_wr_conflict, 1'b0);
        $display("[TB] 32-bit sp write read 0x%0h", b_rd_data_sp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
